// File: rtl/txt_con_writer_pkg.sv
// rtl/txt_con_writer_pkg.sv - shared types, byte codes and cell-word helpers for the text console writer
package txt_con_writer_pkg;

    localparam int          DEF_COLS     = 80;
    localparam int          DEF_ROWS     = 25;
    localparam logic [31:0] DEF_BASE     = 32'h00A0_0000;
    localparam logic [15:0] DEF_ATTR_VAL = 16'h0F00;
    localparam int          IDX_W        = 14;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [2:0] {
        IDLE,
        WRCH,
        CLR,
        SCR_RD,
        SCR_WR,
        SCR_BLANK,
        GAP
    } opState_t;

    typedef struct packed {
        logic [15:0] attr;
        logic [7:0]  rsvd;
        logic [7:0]  ch;
    } cellWord_t;

    function automatic logic [31:0] cellWord(input logic [15:0] attr, input logic [7:0] ch);
        cellWord_t w;
        w.attr = attr;
        w.rsvd = 8'h00;
        w.ch   = ch;
        return w;
    endfunction

    // Each cell occupies four words; only word 0 is ever addressed.
    function automatic logic [31:0] cellAddr(input logic [31:0] base, input logic [IDX_W-1:0] idx);
        return base + {14'd0, idx, 4'd0};
    endfunction

endpackage

// File: rtl/txt_bus_master.sv
// rtl/txt_bus_master.sv - single-outstanding strobe/hold/busOK sequencer with tristate write data
module txt_bus_master (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        startWr,
    input  logic [31:0] startAddr,
    input  logic [31:0] startData,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdData,
    output logic [31:0] busAddr,
    inout  wire  [31:0] busData,
    output logic        busOE,
    output logic        busWR,
    input  logic        busOK
);

    logic [31:0] wrData;
    logic        strobe;

    assign strobe  = busOE | busWR;
    // The completion cycle drops the strobe, so the following cycle is always a low-strobe gap.
    assign ready   = ~strobe;
    assign done    = strobe & busOK;
    assign busData = busWR ? wrData : 32'bz;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busAddr <= '0;
            busOE   <= 1'b0;
            busWR   <= 1'b0;
            wrData  <= '0;
            rdData  <= '0;
        end else if (done) begin
            busOE <= 1'b0;
            busWR <= 1'b0;
            if (busOE) begin
                rdData <= busData;
            end
        end else if (start && ready) begin
            busAddr <= startAddr;
            busOE   <= ~startWr;
            busWR   <= startWr;
            wrData  <= startData;
        end
    end

endmodule

// File: rtl/txt_con_writer.sv
// rtl/txt_con_writer.sv - byte stream to text-cell writes with cursor, clear and scroll-up
module txt_con_writer
    import txt_con_writer_pkg::*;
#(
    parameter int          COLS     = DEF_COLS,
    parameter int          ROWS     = DEF_ROWS,
    parameter logic [31:0] BASE     = DEF_BASE,
    parameter logic [15:0] DEF_ATTR = DEF_ATTR_VAL
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        chValid,
    input  logic [7:0]  chData,
    output logic        chReady,
    input  logic [15:0] attrIn,
    output logic [31:0] busAddr,
    inout  wire  [31:0] busData,
    output logic        busOE,
    output logic        busWR,
    input  logic        busOK,
    output logic [6:0]  curCol,
    output logic [4:0]  curRow,
    output logic        busy
);

    localparam logic [6:0]       COL_MAX     = 7'(COLS - 1);
    localparam logic [4:0]       ROW_MAX     = 5'(ROWS - 1);
    localparam logic [IDX_W-1:0] COLS_IDX    = IDX_W'(COLS);
    localparam logic [IDX_W-1:0] LAST_SCROLL = IDX_W'(COLS * (ROWS - 1) - 1);
    localparam logic [IDX_W-1:0] LAST_CELL   = IDX_W'(COLS * ROWS - 1);

    opState_t         state;
    opState_t         nextState;
    logic [15:0]      curAttr;
    logic [7:0]       chLatch;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] cursorIdx;
    logic             accept;
    logic             atBottom;
    logic             atLastCol;

    logic             busStart;
    logic             busStartWr;
    logic [31:0]      busStartAddr;
    logic [31:0]      busStartData;
    logic             busReady;
    logic             busDone;
    logic [31:0]      busRdData;

    assign chReady   = (state == IDLE) & reset;
    assign busy      = (state != IDLE);
    assign accept    = chValid & chReady;
    assign atBottom  = (curRow == ROW_MAX);
    assign atLastCol = (curCol == COL_MAX);
    assign cursorIdx = IDX_W'(curRow) * COLS_IDX + IDX_W'(curCol);

    txt_bus_master uBus (
        .clock     (clock),
        .reset     (reset),
        .start     (busStart),
        .startWr   (busStartWr),
        .startAddr (busStartAddr),
        .startData (busStartData),
        .ready     (busReady),
        .done      (busDone),
        .rdData    (busRdData),
        .busAddr   (busAddr),
        .busData   (busData),
        .busOE     (busOE),
        .busWR     (busWR),
        .busOK     (busOK)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (chData >= CH_SPACE) begin
                        nextState = WRCH;
                    end else if (chData == CH_FF) begin
                        nextState = CLR;
                    end else if (chData == CH_LF && atBottom) begin
                        nextState = SCR_RD;
                    end else begin
                        nextState = GAP;
                    end
                end
            end
            WRCH:      if (busDone) nextState = (atLastCol && atBottom) ? SCR_RD : GAP;
            CLR:       if (busDone && idx == LAST_CELL) nextState = IDLE;
            SCR_RD:    if (busDone) nextState = SCR_WR;
            SCR_WR:    if (busDone) nextState = (idx == LAST_SCROLL) ? SCR_BLANK : SCR_RD;
            SCR_BLANK: if (busDone && idx == LAST_CELL) nextState = IDLE;
            GAP:       nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    // A new bus cycle is requested whenever the sequencer is free, which lands on the gap cycle.
    always_comb begin
        busStart     = 1'b0;
        busStartWr   = 1'b1;
        busStartAddr = cellAddr(BASE, idx);
        busStartData = cellWord(curAttr, CH_SPACE);
        case (state)
            WRCH: begin
                busStart     = busReady;
                busStartAddr = cellAddr(BASE, cursorIdx);
                busStartData = cellWord(curAttr, chLatch);
            end
            CLR, SCR_BLANK: begin
                busStart = busReady;
            end
            SCR_RD: begin
                busStart     = busReady;
                busStartWr   = 1'b0;
                busStartAddr = cellAddr(BASE, idx + COLS_IDX);
            end
            SCR_WR: begin
                busStart     = busReady;
                busStartData = busRdData;
            end
            default: begin
                busStart = 1'b0;
            end
        endcase
    end

    // The index counter runs 0..last cell: copy phase below LAST_SCROLL, blank phase after it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            curCol  <= '0;
            curRow  <= '0;
            curAttr <= DEF_ATTR;
            chLatch <= '0;
            idx     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        idx <= '0;
                        if (chData >= CH_SPACE) begin
                            chLatch <= chData;
                            curAttr <= attrIn;
                        end else begin
                            case (chData)
                                CH_CR: curCol <= '0;
                                CH_LF: if (!atBottom) curRow <= curRow + 5'd1;
                                CH_BS: if (curCol != 7'd0) curCol <= curCol - 7'd1;
                                CH_FF: begin
                                    curCol <= '0;
                                    curRow <= '0;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                WRCH: begin
                    if (busDone) begin
                        if (atLastCol) begin
                            curCol <= '0;
                            if (!atBottom) curRow <= curRow + 5'd1;
                        end else begin
                            curCol <= curCol + 7'd1;
                        end
                    end
                end
                CLR, SCR_WR, SCR_BLANK: begin
                    if (busDone) idx <= idx + 14'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_txt_con_writer.sv
// tb/tb_txt_con_writer.sv - directed and randomized bench with a screen-level reference model
module tb_txt_con_writer;

    localparam int          COLS  = 80;
    localparam int          ROWS  = 25;
    localparam int          NCELL = COLS * ROWS;
    localparam logic [31:0] BASE  = 32'h00A0_0000;
    localparam int          TMO   = 20000;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
    } tx_t;

    logic        clock;
    logic        reset;
    logic        chValid;
    logic [7:0]  chData;
    logic        chReady;
    logic [15:0] attrIn;
    logic [31:0] busAddr;
    wire  [31:0] busData;
    logic        busOE;
    logic        busWR;
    logic        busOK;
    logic [6:0]  curCol;
    logic [4:0]  curRow;
    logic        busy;

    logic        tbDrv;
    logic [31:0] rdDrive;
    logic        probeDrv;
    logic [31:0] probeVal;

    assign busData = tbDrv ? rdDrive : (probeDrv ? probeVal : 32'bz);

    txt_con_writer #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .BASE     (BASE),
        .DEF_ATTR (16'h0F00)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .chValid (chValid),
        .chData  (chData),
        .chReady (chReady),
        .attrIn  (attrIn),
        .busAddr (busAddr),
        .busData (busData),
        .busOE   (busOE),
        .busWR   (busWR),
        .busOK   (busOK),
        .curCol  (curCol),
        .curRow  (curRow),
        .busy    (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Slave memory and bus log (written only by the slave process)
    logic [31:0] mem [0:NCELL-1];
    tx_t         txLog[$];
    int          nWr = 0, nRd = 0, strobeCycles = 0, protoErr = 0, readyBusyErr = 0;
    int          fixedDelay = -1;
    int          cnt, curDelay;
    logic [31:0] holdAddr, holdData, off;
    logic        holdWr;

    initial begin
        busOK = 1'b0; tbDrv = 1'b0; rdDrive = '0; cnt = 0; curDelay = 0;
        for (int i = 0; i < NCELL; i++) mem[i] = $urandom;
        forever begin
            @(negedge clock);
            if (!reset) begin
                busOK = 1'b0; tbDrv = 1'b0; cnt = 0;
            end else if (busOK) begin
                busOK = 1'b0; tbDrv = 1'b0; cnt = 0;
                if (busOE || busWR) protoErr++;
            end else if (busOE || busWR) begin
                strobeCycles++;
                if (busOE && busWR) protoErr++;
                if (cnt == 0) begin
                    holdAddr = busAddr; holdWr = busWR; holdData = busData;
                    curDelay = (fixedDelay >= 0) ? fixedDelay : int'($urandom_range(0, 2));
                end else if (busAddr !== holdAddr || busWR !== holdWr || (busWR && busData !== holdData)) begin
                    protoErr++;
                end
                if (cnt >= curDelay) begin
                    off = busAddr - BASE;
                    if (off[3:0] != 4'd0 || off >= 32'(NCELL * 16)) begin
                        protoErr++;
                    end else if (busWR) begin
                        mem[int'(off >> 4)] = busData;
                        nWr++;
                        txLog.push_back('{1'b1, busAddr, busData});
                    end else begin
                        rdDrive = mem[int'(off >> 4)];
                        tbDrv   = 1'b1;
                        nRd++;
                        txLog.push_back('{1'b0, busAddr, rdDrive});
                    end
                    busOK = 1'b1;
                end else begin
                    cnt++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (chReady && busy) readyBusyErr++;
        end
    end

    // Screen-level reference model
    logic [31:0] scr [0:NCELL-1];
    int          mRow, mCol, expRd, expWr;
    logic [15:0] mAttr;
    int          checks = 0, errors = 0;
    int          logOff;
    logic        readyAfterAccept;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic lineFeed();
        if (mRow < ROWS - 1) begin
            mRow++;
        end else begin
            for (int i = 0; i < NCELL - COLS; i++) scr[i] = scr[i + COLS];
            for (int i = NCELL - COLS; i < NCELL; i++) scr[i] = {mAttr, 16'h0020};
            expRd += NCELL - COLS;
            expWr += NCELL;
        end
    endtask

    task automatic modelApply(input logic [7:0] ch, input logic [15:0] a);
        expRd = 0;
        expWr = 0;
        if (ch >= 8'h20) begin
            mAttr = a;
            scr[mRow * COLS + mCol] = {a, 8'h00, ch};
            expWr = 1;
            mCol++;
            if (mCol == COLS) begin
                mCol = 0;
                lineFeed();
            end
        end else begin
            case (ch)
                8'h0D: mCol = 0;
                8'h0A: lineFeed();
                8'h08: if (mCol > 0) mCol--;
                8'h0C: begin
                    for (int i = 0; i < NCELL; i++) scr[i] = {mAttr, 16'h0020};
                    expWr = NCELL;
                    mRow = 0;
                    mCol = 0;
                end
                default: begin
                end
            endcase
        end
    endtask

    task automatic waitReady();
        int t;
        t = 0;
        @(negedge clock);
        while (!chReady && t < TMO) begin
            @(negedge clock);
            t++;
        end
        check("ready_timeout", 32'(t < TMO), 32'd1);
    endtask

    task automatic memCompare(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < NCELL; i++) if (mem[i] !== scr[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic sendByte(input logic [7:0] ch, input logic [15:0] a);
        int rd0, wr0;
        waitReady();
        rd0 = nRd;
        wr0 = nWr;
        logOff = txLog.size();
        modelApply(ch, a);
        chValid = 1'b1; chData = ch; attrIn = a;
        @(posedge clock);
        #1;
        readyAfterAccept = chReady;
        chValid = 1'b0; chData = 8'($urandom); attrIn = 16'($urandom);
        waitReady();
        check("curCol", 32'(curCol), 32'(mCol));
        check("curRow", 32'(curRow), 32'(mRow));
        check("reads", 32'(nRd - rd0), 32'(expRd));
        check("writes", 32'(nWr - wr0), 32'(expWr));
        memCompare("memory");
        check("protocol", 32'(protoErr + readyBusyErr), 32'd0);
    endtask

    task automatic checkClear(input logic [31:0] blank);
        int bad;
        bad = 0;
        for (int i = logOff; i < txLog.size(); i++) if (!txLog[i].wr || txLog[i].data !== blank) bad++;
        check("clr_data", 32'(bad), 32'd0);
        check("clr_first", txLog[logOff].addr, BASE);
        check("clr_last", txLog[txLog.size() - 1].addr, BASE + 32'd31984);
    endtask

    initial begin
        int t, s0, n0;
        reset = 1'b0; chValid = 1'b0; chData = '0; attrIn = '0;
        probeDrv = 1'b0; probeVal = '0; readyAfterAccept = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_col", 32'(curCol), 32'd0);
        check("rst_row", 32'(curRow), 32'd0);
        check("rst_oe", 32'(busOE), 32'd0);
        check("rst_wr", 32'(busWR), 32'd0);
        check("rst_addr", busAddr, 32'd0);
        check("rst_ready", 32'(chReady), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NCELL; i++) scr[i] = mem[i];
        mRow = 0; mCol = 0; mAttr = 16'h0F00;
        reset = 1'b1;
        @(negedge clock);
        check("idle_ready", 32'(chReady), 32'd1);

        fixedDelay = 0;
        sendByte(8'h41, 16'h1F00);
        check("a_ready_after_accept", 32'(readyAfterAccept), 32'd0);
        check("a_count", 32'(txLog.size() - logOff), 32'd1);
        check("a_addr", txLog[logOff].addr, BASE);
        check("a_data", txLog[logOff].data, 32'h1F000041);
        check("a_col", 32'(curCol), 32'd1);

        fixedDelay = 5;
        s0 = strobeCycles;
        sendByte(8'h42, 16'h2E00);
        n0 = txLog.size();
        repeat (5) @(negedge clock);
        check("slow_strobe_cycles", 32'(strobeCycles - s0), 32'd6);
        check("slow_single_strobe", 32'(txLog.size() - n0), 32'd0);
        check("slow_addr", txLog[logOff].addr, BASE + 32'd16);
        fixedDelay = -1;

        for (int i = 0; i < 78; i++) sendByte(8'($urandom_range(32, 255)), 16'($urandom));
        check("row0_full_col", 32'(curCol), 32'd0);
        check("row0_full_row", 32'(curRow), 32'd1);

        n0 = txLog.size();
        sendByte(8'h0D, 16'h0000);
        sendByte(8'h08, 16'h0000);
        check("cr_bs_col", 32'(curCol), 32'd0);
        check("cr_bs_nobus", 32'(txLog.size() - n0), 32'd0);

        sendByte(8'h0C, 16'h7700);
        checkClear({mAttr, 16'h0020});

        for (int i = 0; i < 24; i++) sendByte(8'h0A, 16'h0000);
        for (int i = 0; i < 5; i++) sendByte(8'($urandom_range(32, 255)), 16'($urandom));
        sendByte(8'h0A, 16'h0000);
        check("scr_first_rd", txLog[logOff].addr, BASE + 32'd1280);
        check("scr_first_rd_kind", 32'(txLog[logOff].wr), 32'd0);
        check("scr_first_wr", txLog[logOff + 1].addr, BASE);
        check("scr_blank_first", txLog[logOff + 3840].addr, BASE + 32'd30720);
        check("scr_row", 32'(curRow), 32'd24);
        check("scr_col", 32'(curCol), 32'd5);

        sendByte(8'h0D, 16'h0000);
        for (int i = 0; i < 79; i++) sendByte(8'($urandom_range(32, 255)), 16'($urandom));
        sendByte(8'h5A, 16'h4A00);
        check("wrap_first_addr", txLog[logOff].addr, BASE + 32'd31984);
        check("wrap_first_data", txLog[logOff].data, 32'h4A00005A);
        check("wrap_then_read", txLog[logOff + 1].addr, BASE + 32'd1280);

        waitReady();
        chValid = 1'b1; chData = 8'h0A; attrIn = 16'h0000;
        @(posedge clock);
        #1;
        chValid = 1'b0;
        t = 0;
        while (busWR !== 1'b1 && t < TMO) begin
            @(negedge clock);
            t++;
        end
        check("mid_wr_seen", 32'(t < TMO), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("abort_wr", 32'(busWR), 32'd0);
        check("abort_oe", 32'(busOE), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_addr", busAddr, 32'd0);
        check("abort_ready", 32'(chReady), 32'd0);
        probeVal = 32'h5A5A_A5A5;
        probeDrv = 1'b1;
        #1;
        check("abort_bus_released", busData, 32'h5A5A_A5A5);
        probeDrv = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("post_ready", 32'(chReady), 32'd1);
        check("post_col", 32'(curCol), 32'd0);
        check("post_row", 32'(curRow), 32'd0);
        mRow = 0; mCol = 0; mAttr = 16'h0F00;
        for (int i = 0; i < NCELL; i++) scr[i] = mem[i];

        sendByte(8'h0C, 16'h1234);
        checkClear(32'h0F000020);

        for (int i = 0; i < 40; i++) begin
            logic [7:0] c;
            case ($urandom_range(0, 9))
                0: c = 8'h0D;
                1: c = 8'h0A;
                2: c = 8'h08;
                3: begin
                    c = 8'($urandom_range(0, 31));
                    if (c == 8'h0C) c = 8'h01;
                end
                default: c = 8'($urandom_range(32, 255));
            endcase
            sendByte(c, 16'($urandom));
        end

        check("protocol_final", 32'(protoErr + readyBusyErr), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
